unidade_controle_rodadas: RTL
=============================

Name: unidade_controle_rodadas

Overview:
- Moore FSM that sequences the round-based memory-game datapath (address counter, round counter, move register, comparator, move-timeout timer).
- Each round: display memory entries 0..round via LEDs (timed on/off), then collect the player's moves and compare each one, then advance the round.
- Sits beside the datapath in the game top level and replaces the single-pass control unit.
- Owns an internal display timer; all other counters live in the datapath.

Parameters:
- T_MOSTRA, default 1000: clock cycles each entry is shown (LEDs on); must be >= 1.
- T_APAGADO, default 250: clock cycles LEDs are dark between entries; must be >= 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 forces state inicial.
- iniciar  input  1  start/restart request, level-sampled.
- jogada  input  1  one-cycle pulse, player move detected.
- igual  input  1  registered move == memory[address].
- enderecoIgualRodada  input  1  address counter == round counter.
- fimR  input  1  round counter at last round (15).
- timeout  input  1  move timer expired.
- zeraE, contaE  output  1  clear / increment address counter.
- zeraRod, contaRod  output  1  clear / increment round counter.
- zeraReg, registraReg  output  1  clear / load move register.
- zeraTO, contaTO  output  1  clear / enable move-timeout timer.
- mostra_leds  output  1  drive LEDs from memory data.
- pronto, ganhou, perdeu  output  1  game finished / win / loss (loss includes timeout).
- db_timeout  output  1  high in state tout.
- db_estado  output  4  state code below.

Behaviour:
- States (db_estado): inicial 0, preparacao 1, inicio_rodada 2, mostra 3, apaga 4, prox_mostra 5, fim_mostra 6, espera 7, registra 8, comparacao 9, proxima_jogada A, proxima_rodada B, tout C, vitoria D, derrota E; unused codes go to inicial.
- Reset: state inicial, display timer 0. Outputs: zeraE=zeraRod=zeraReg=zeraTO=1, all others 0, db_estado=0.
- Transitions:
  - inicial: iniciar -> preparacao, else stay.
  - preparacao -> inicio_rodada.
  - inicio_rodada -> mostra.
  - mostra: stays T_MOSTRA cycles -> apaga.
  - apaga: stays T_APAGADO cycles, then enderecoIgualRodada ? fim_mostra : prox_mostra.
  - prox_mostra -> mostra.
  - fim_mostra -> espera.
  - espera: timeout -> tout; else jogada -> registra; else stay. timeout has priority when both are high.
  - registra -> comparacao.
  - comparacao: !igual -> derrota; else enderecoIgualRodada&fimR -> vitoria; else enderecoIgualRodada -> proxima_rodada; else proxima_jogada.
  - proxima_jogada -> espera.
  - proxima_rodada -> inicio_rodada.
  - tout/vitoria/derrota: iniciar -> preparacao, else hold.
- Outputs (Moore, decoded from state only):
  - zeraE: inicial, preparacao, inicio_rodada, fim_mostra.
  - zeraRod: inicial, preparacao.
  - zeraReg: inicial, preparacao, fim_mostra.
  - zeraTO: inicial, preparacao, fim_mostra, proxima_jogada.
  - contaE: prox_mostra, proxima_jogada.
  - contaRod: proxima_rodada.
  - registraReg: registra.
  - contaTO: espera.
  - mostra_leds: mostra.
  - pronto: tout, vitoria, derrota.
  - ganhou: vitoria.
  - perdeu: tout, derrota.
  - db_timeout: tout.
- Display timer: width clog2(max(T_MOSTRA,T_APAGADO))+1. Cleared on every transition into mostra or apaga, increments each cycle while in them. Exit when count == T-1, so mostra_leds is high exactly T_MOSTRA consecutive cycles per entry.
- Round r (0-based) shows r+1 entries and accepts r+1 moves. A full 16-round game ends in vitoria.
- jogada pulses outside espera are ignored.
- iniciar held high in a terminal state restarts only once; preparacao never re-enters itself.
- reset low in any state, including mid-display, returns to inicial within the same cycle (asynchronous) and clears the timer.

Test Plan:
- Reset/idle (T_MOSTRA=4, T_APAGADO=2): reset=0 -> db_estado=0, zeraE=zeraRod=1, pronto=0; iniciar=0 for 10 cycles -> stays 0.
- Round 0 display and play: iniciar pulse, enderecoIgualRodada=1 -> mostra_leds high exactly 4 cycles, 2 dark, then espera (7). jogada with igual=1, fimR=0 -> proxima_rodada (B), contaRod one cycle, back to inicio_rodada (2).
- Round 2 display: enderecoIgualRodada=0 for the first two entries -> three mostra periods (4 cycles each), two contaE pulses, fim_mostra (6); then three correct moves -> two proxima_jogada (A) visits.
- Full win: 16 rounds with a model datapath -> vitoria (D), pronto=ganhou=1, perdeu=0; iniciar -> preparacao (1).
- Wrong move / timeout: igual=0 at comparacao -> derrota (E), perdeu=1. Separately, timeout and jogada high together in espera -> tout (C), db_timeout=1, registraReg never asserted.
- Reset mid-operation: reset=0 during the second mostra cycle -> immediately db_estado=0, mostra_leds=0; after release, display restarts with a full 4-cycle mostra period.

Source files
------------

// File: rtl/unidade_controle_rodadas.sv
// Round sequencer for the memory game: shows entries 0..round on the LEDs,
// collects and checks the player's moves, then advances to the next round.
module unidade_controle_rodadas #(
  parameter int unsigned T_MOSTRA  = 1000,
  parameter int unsigned T_APAGADO = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       fimR,
  input  logic       timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraRod,
  output logic       contaRod,
  output logic       zeraReg,
  output logic       registraReg,
  output logic       zeraTO,
  output logic       contaTO,
  output logic       mostra_leds,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam int unsigned T_MAX = (T_MOSTRA > T_APAGADO) ? T_MOSTRA : T_APAGADO;
  localparam int unsigned TW    = $clog2(T_MAX) + 1;

  typedef enum logic [3:0] {
    inicial        = 4'h0,
    preparacao     = 4'h1,
    inicio_rodada  = 4'h2,
    mostra         = 4'h3,
    apaga          = 4'h4,
    prox_mostra    = 4'h5,
    fim_mostra     = 4'h6,
    espera         = 4'h7,
    registra       = 4'h8,
    comparacao     = 4'h9,
    proxima_jogada = 4'hA,
    proxima_rodada = 4'hB,
    tout           = 4'hC,
    vitoria        = 4'hD,
    derrota        = 4'hE
  } estado_t;

  estado_t         estado_atual, estado_prox;
  logic [TW-1:0]   timer;
  logic            fim_t_mostra, fim_t_apagado;

  logic zeraE_c, contaE_c, zeraRod_c, contaRod_c, zeraReg_c, registraReg_c;
  logic zeraTO_c, contaTO_c, mostra_leds_c, pronto_c, ganhou_c, perdeu_c;
  logic db_timeout_c;

  assign fim_t_mostra  = (timer == TW'(T_MOSTRA - 1));
  assign fim_t_apagado = (timer == TW'(T_APAGADO - 1));
  assign db_estado     = estado_atual;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado_atual <= inicial;
    else        estado_atual <= estado_prox;
  end

  // Display timer: restarts on every state change, counts while showing or dark
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (estado_prox != estado_atual) begin
      timer <= '0;
    end else if (estado_atual == mostra || estado_atual == apaga) begin
      timer <= timer + TW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    estado_prox = estado_atual;
    case (estado_atual)
      inicial:        if (iniciar) estado_prox = preparacao;
      preparacao:     estado_prox = inicio_rodada;
      inicio_rodada:  estado_prox = mostra;
      mostra:         if (fim_t_mostra) estado_prox = apaga;
      apaga:          if (fim_t_apagado)
                        estado_prox = enderecoIgualRodada ? fim_mostra : prox_mostra;
      prox_mostra:    estado_prox = mostra;
      fim_mostra:     estado_prox = espera;
      espera:         if (timeout)     estado_prox = tout;
                      else if (jogada) estado_prox = registra;
      registra:       estado_prox = comparacao;
      comparacao:     if (!igual)                          estado_prox = derrota;
                      else if (enderecoIgualRodada && fimR) estado_prox = vitoria;
                      else if (enderecoIgualRodada)         estado_prox = proxima_rodada;
                      else                                  estado_prox = proxima_jogada;
      proxima_jogada: estado_prox = espera;
      proxima_rodada: estado_prox = inicio_rodada;
      tout, vitoria, derrota:
                      if (iniciar) estado_prox = preparacao;
      default:        estado_prox = inicial;
    endcase
  end

  // Moore decode of the state being entered, so the registered outputs track the state
  always_comb begin
    zeraE_c       = 1'b0;
    contaE_c      = 1'b0;
    zeraRod_c     = 1'b0;
    contaRod_c    = 1'b0;
    zeraReg_c     = 1'b0;
    registraReg_c = 1'b0;
    zeraTO_c      = 1'b0;
    contaTO_c     = 1'b0;
    mostra_leds_c = 1'b0;
    pronto_c      = 1'b0;
    ganhou_c      = 1'b0;
    perdeu_c      = 1'b0;
    db_timeout_c  = 1'b0;
    case (estado_prox)
      inicial, preparacao: begin
        zeraE_c = 1'b1; zeraRod_c = 1'b1; zeraReg_c = 1'b1; zeraTO_c = 1'b1;
      end
      inicio_rodada:  zeraE_c = 1'b1;
      mostra:         mostra_leds_c = 1'b1;
      prox_mostra:    contaE_c = 1'b1;
      fim_mostra: begin
        zeraE_c = 1'b1; zeraReg_c = 1'b1; zeraTO_c = 1'b1;
      end
      espera:         contaTO_c = 1'b1;
      registra:       registraReg_c = 1'b1;
      proxima_jogada: begin
        contaE_c = 1'b1; zeraTO_c = 1'b1;
      end
      proxima_rodada: contaRod_c = 1'b1;
      tout: begin
        pronto_c = 1'b1; perdeu_c = 1'b1; db_timeout_c = 1'b1;
      end
      vitoria: begin
        pronto_c = 1'b1; ganhou_c = 1'b1;
      end
      derrota: begin
        pronto_c = 1'b1; perdeu_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      zeraE       <= 1'b1;
      contaE      <= 1'b0;
      zeraRod     <= 1'b1;
      contaRod    <= 1'b0;
      zeraReg     <= 1'b1;
      registraReg <= 1'b0;
      zeraTO      <= 1'b1;
      contaTO     <= 1'b0;
      mostra_leds <= 1'b0;
      pronto      <= 1'b0;
      ganhou      <= 1'b0;
      perdeu      <= 1'b0;
      db_timeout  <= 1'b0;
    end else begin
      zeraE       <= zeraE_c;
      contaE      <= contaE_c;
      zeraRod     <= zeraRod_c;
      contaRod    <= contaRod_c;
      zeraReg     <= zeraReg_c;
      registraReg <= registraReg_c;
      zeraTO      <= zeraTO_c;
      contaTO     <= contaTO_c;
      mostra_leds <= mostra_leds_c;
      pronto      <= pronto_c;
      ganhou      <= ganhou_c;
      perdeu      <= perdeu_c;
      db_timeout  <= db_timeout_c;
    end
  end

endmodule
